// File: rtl/im_loader.sv
// Instruction memory loader: frames a serial byte stream into big-endian 32-bit
// words and writes them into the main-code or exception-handler region.
module im_loader #(
    parameter logic [31:0] MAIN_BASE     = 32'h0000_3000,
    parameter logic [31:0] HANDLER_BASE  = 32'h0000_4180,
    parameter int unsigned MAIN_WORDS    = 1120,
    parameter int unsigned HANDLER_WORDS = 928
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic        region;
    logic [31:0] addr;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    logic        xfer;
    logic        hdr_ok;
    logic [15:0] len_full;
    logic [15:0] limit;

    assign xfer     = byte_valid & byte_ready;
    assign hdr_ok   = (byte_in[7:1] == 7'd0);
    assign len_full = {count[15:8], byte_in};
    assign limit    = region ? 16'(HANDLER_WORDS) : 16'(MAIN_WORDS);
    assign cpu_hold = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        case (state)
            IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid && hdr_ok)
                    state_nxt = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid)
                    state_nxt = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len_full == 16'd0)
                        state_nxt = DONE;
                    else if (len_full > limit)
                        state_nxt = IDLE;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_idx == 2'd3)
                    state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = (count == 16'd1) ? DONE : DATA;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write-port signals are registered when the 4th byte lands so they are
    // presented for exactly the single WRITE-state cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            region   <= 1'b0;
            addr     <= '0;
            count    <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            im_we <= 1'b0;
            done  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (hdr_ok) begin
                            region <= byte_in[0];
                            addr   <= byte_in[0] ? HANDLER_BASE : MAIN_BASE;
                            err    <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LEN_HI: begin
                    if (xfer)
                        count[15:8] <= byte_in;
                end
                LEN_LO: begin
                    if (xfer) begin
                        count[7:0] <= byte_in;
                        byte_idx   <= '0;
                        if (len_full > limit)
                            err <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_addr  <= addr;
                            im_wdata <= {word_buf, byte_in};
                            byte_idx <= '0;
                        end else begin
                            word_buf <= {word_buf[15:0], byte_in};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    addr  <= addr + 32'd4;
                    count <= count - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a frame-level model predicts the writes and
// done pulse of each frame; a negedge monitor compares them as they appear.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    localparam logic [31:0] MAIN_BASE     = 32'h0000_3000;
    localparam logic [31:0] HANDLER_BASE  = 32'h0000_4180;
    localparam int unsigned MAIN_WORDS    = 1120;
    localparam int unsigned HANDLER_WORDS = 928;

    im_loader #(
        .MAIN_BASE     (MAIN_BASE),
        .HANDLER_BASE  (HANDLER_BASE),
        .MAIN_WORDS    (MAIN_WORDS),
        .HANDLER_WORDS (HANDLER_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned lat;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] data_q[$];
    ev_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned last_xfer = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (im_we === 1'b1 || done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: im_we=%0b done=%0b addr=0x%08h with nothing expected",
                         im_we, done, im_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind_done", 32'(done), 32'(mon_e.is_done));
                if (!mon_e.is_done) begin
                    check("im_addr", im_addr, mon_e.addr);
                    check("im_wdata", im_wdata, mon_e.data);
                    check("we_latency", cyc - last_xfer, 32'd1);
                    check("ready_during_write", 32'(byte_ready), 32'd0);
                    check("hold_during_write", 32'(cpu_hold), 32'd1);
                end else begin
                    check("done_latency", cyc - last_xfer, mon_e.lat);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int unsigned tries;
        int unsigned gap;
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        tries = 0;
        while (byte_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got ready=%0b expected 1 within 20 cycles", byte_ready);
            byte_valid = 1'b0;
        end else begin
            last_xfer = cyc;
            @(posedge clk);
        end
    endtask

    // Model: a frame is valid when the header is 0/1 and N fits its region;
    // it then produces N writes at base+4i followed by one done pulse.
    task automatic run_frame(input logic [7:0] hdr, input logic [15:0] n, input int unsigned max_gap);
        logic [31:0] base;
        int unsigned limit;
        bit          exp_err;
        logic [31:0] words[$];
        int unsigned tries;
        logic [31:0] w;
        words.delete();
        base  = (hdr == 8'h01) ? HANDLER_BASE : MAIN_BASE;
        limit = (hdr == 8'h01) ? HANDLER_WORDS : MAIN_WORDS;
        if (hdr > 8'h01) begin
            exp_err = 1'b1;
            send_byte(hdr, max_gap);
        end else if (int'(n) > limit) begin
            exp_err = 1'b1;
            send_byte(hdr, max_gap);
            send_byte(n[15:8], max_gap);
            send_byte(n[7:0], max_gap);
        end else begin
            exp_err = 1'b0;
            for (int i = 0; i < int'(n); i++) begin
                w = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
                words.push_back(w);
                exp_q.push_back('{1'b0, base + 32'(4 * i), w, 1});
            end
            exp_q.push_back('{1'b1, 32'd0, 32'd0, (n == 16'd0) ? 2 : 3});
            send_byte(hdr, max_gap);
            send_byte(n[15:8], max_gap);
            send_byte(n[7:0], max_gap);
            foreach (words[i]) begin
                w = words[i];
                send_byte(w[31:24], max_gap);
                send_byte(w[23:16], max_gap);
                send_byte(w[15:8], max_gap);
                send_byte(w[7:0], max_gap);
            end
        end
        data_q.delete();
        tries = 0;
        do begin
            @(negedge clk);
            byte_valid = 1'b0;
            tries++;
        end while ((exp_q.size() != 0 || cpu_hold !== 1'b0) && tries < 50);
        if (tries >= 50) begin
            checks++;
            errors++;
            $display("FAIL frame_drain_timeout: got %0d pending events hold=%0b expected 0 and 0",
                     exp_q.size(), cpu_hold);
            exp_q.delete();
        end
        check("err_after_frame", 32'(err), 32'(exp_err));
        check("hold_after_frame", 32'(cpu_hold), 32'd0);
        check("ready_after_frame", 32'(byte_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
        check({tag, "_im_we"}, 32'(im_we), 32'd0);
        check({tag, "_im_addr"}, im_addr, 32'd0);
        check({tag, "_im_wdata"}, im_wdata, 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  hdr;
        logic [15:0] n;
        int unsigned r;
        int unsigned lim;

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        data_q = '{32'h3C01_0000, 32'h3421_0005};
        run_frame(8'h00, 16'd2, 0);

        data_q = '{32'h4200_0018};
        run_frame(8'h01, 16'd1, 0);

        run_frame(8'h00, 16'h0461, 0);
        run_frame(8'h01, 16'd1, 1);

        run_frame(8'h7F, 16'd0, 0);
        run_frame(8'h7F, 16'd0, 0);
        run_frame(8'h00, 16'd3, 2);

        run_frame(8'h00, 16'd0, 0);

        // Mid-frame reset: only the first complete word may reach memory.
        exp_q.push_back('{1'b0, MAIN_BASE, 32'h1122_3344, 1});
        send_byte(8'h00, 0);
        send_byte(8'h00, 1);
        send_byte(8'h02, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 0);
        send_byte(8'h33, 3);
        send_byte(8'h44, 1);
        send_byte(8'h55, 2);
        send_byte(8'h66, 3);
        @(negedge clk);
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset_pending_events", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        run_frame(8'h01, 16'(HANDLER_WORDS), 0);
        run_frame(8'h01, 16'(HANDLER_WORDS + 1), 0);
        run_frame(8'h00, 16'(MAIN_WORDS), 0);

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4)
                hdr = 8'h00;
            else if (r < 8)
                hdr = 8'h01;
            else
                hdr = 8'($urandom_range(2, 255));
            lim = (hdr == 8'h01) ? HANDLER_WORDS : MAIN_WORDS;
            if ($urandom_range(0, 7) == 0)
                n = 16'(lim + $urandom_range(1, 100));
            else
                n = 16'($urandom_range(0, 6));
            run_frame(hdr, n, 3);
        end

        check("final_pending_events", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
